// File: rtl/arith_accum_unit_if.sv
// Operand, button and display bundle for arith_accum_unit.
// The master drives the switches and buttons. The slave (the unit) drives the display outputs.
interface arith_accum_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             btn_exec;
  logic             btn_clear;
  logic             btn_prev;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             done;
  logic             busy;
  logic [CW-1:0]    count;
  logic [PW-1:0]    view_idx;

  modport master (
    output op_a, op_b, mode, btn_exec, btn_clear, btn_prev,
    input  result, carry, done, busy, count, view_idx
  );

  modport slave (
    input  op_a, op_b, mode, btn_exec, btn_clear, btn_prev,
    output result, carry, done, busy, count, view_idx
  );
endinterface

// File: rtl/arith_accum_unit.sv
// Switch calculator that runs add, subtract or accumulate on an exec button press.
// It keeps a ring history of the last DEPTH results, and prev scrolls through that history.
module arith_accum_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  arith_accum_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       btn_now, btn_q, press_r;
  logic             clr_p, exe_p, prv_p;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [1:0]       mode_r;
  logic [WIDTH:0]   calc_nxt, calc_r;
  logic [WIDTH:0]   hist [DEPTH];
  logic [PW-1:0]    wr_ptr, view_idx, nxt_view, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result;
  logic             carry, done, hist_we;

  assign btn_now = {bus.btn_prev, bus.btn_exec, bus.btn_clear};
  assign clr_p   = press_r[0];
  assign exe_p   = press_r[1];
  assign prv_p   = press_r[2];

  // Delay registers reset high, so a button held through reset never produces a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q   <= '1;
      press_r <= '0;
    end else begin
      btn_q   <= btn_now;
      press_r <= btn_now & ~btn_q;
    end
  end

  always_comb begin
    case (mode_r)
      2'b01:   calc_nxt = {1'b0, a_r} - {1'b0, b_r};
      2'b10:   calc_nxt = {1'b0, acc} + {1'b0, a_r};
      default: calc_nxt = {1'b0, a_r} + {1'b0, b_r};
    endcase
  end

  always_comb begin
    nxt_view = view_idx + PW'(1);
    if (CW'(view_idx) + CW'(1) == count) nxt_view = '0;
  end

  assign rd_ptr  = wr_ptr - PW'(1) - nxt_view;
  assign hist_we = (state == S_WRITE) && !clr_p;

  always_ff @(posedge clk) begin
    if (hist_we) hist[wr_ptr] <= calc_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= '0;
      acc      <= '0;
      calc_r   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      view_idx <= '0;
      result   <= '0;
      carry    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr_p) begin
        state    <= S_IDLE;
        acc      <= '0;
        count    <= '0;
        wr_ptr   <= '0;
        view_idx <= '0;
        result   <= '0;
        carry    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (exe_p) begin
              a_r    <= bus.op_a;
              b_r    <= bus.op_b;
              mode_r <= bus.mode;
              state  <= S_CALC;
            end else if (prv_p && count != '0) begin
              view_idx <= nxt_view;
              {carry, result} <= hist[rd_ptr];
            end
          end
          S_CALC: begin
            calc_r <= calc_nxt;
            if (mode_r == 2'b10) acc <= calc_nxt[WIDTH-1:0];
            state <= S_WRITE;
          end
          S_WRITE: begin
            wr_ptr   <= wr_ptr + PW'(1);
            count    <= (count == CW'(DEPTH)) ? count : count + CW'(1);
            view_idx <= '0;
            {carry, result} <= calc_r;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.result   = result;
  assign bus.carry    = carry;
  assign bus.done     = done;
  assign bus.busy     = (state != S_IDLE);
  assign bus.count    = count;
  assign bus.view_idx = view_idx;
endmodule
